ecpri_axil_regbank: RTL and testbench
=====================================

Name: ecpri_axil_regbank

Overview:
Parametrised AXI4-Lite slave register bank for the eCPRI IP control plane. It generalises the fixed four-register S00_AXI slave to NUM_REGS registers of DATA_WIDTH bits. It adds byte strobes, read-only status registers fed from the datapath, per-register write-strobe pulses and SLVERR decoding. It sits between the AXI interconnect and the eCPRI framer/deframer configuration inputs.

Parameters:
DATA_WIDTH, 32, AXI data width; only 32 or 64 are legal.
ADDR_WIDTH, 6, AXI byte address width; must satisfy 2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8.
NUM_REGS, 8, number of register slots, 1..64.
RO_MASK, 0, NUM_REGS-bit mask; bit i=1 makes register i read-only, sourced from status_in.

Ports:
ACLK  in  1  clock; all logic on rising edge
ARESET  in  1  synchronous active-high reset
S_AXI_AWADDR  in  ADDR_WIDTH  write address
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  DATA_WIDTH  write data
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  ADDR_WIDTH  read address
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  DATA_WIDTH  read data
S_AXI_RRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
reg_out  out  NUM_REGS*DATA_WIDTH  flattened RW register contents; register i is at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on each successful write to register i
status_in  in  NUM_REGS*DATA_WIDTH  read value for RO registers; ignored for RW slots

Behaviour:
- Reset (ARESET=1 at an edge): all RW registers=0; AWREADY=WREADY=ARREADY=0; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0; reg_wr_pulse=0. In-flight transactions are discarded. READY outputs go high on the first edge after ARESET deasserts.
- Register index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)]. The low address bits are ignored.
- Write FSM states:
  - W_COLLECT: AWREADY=1 until an AW is latched; WREADY=1 until a W is latched. AW and W are accepted independently, in either order or in the same cycle.
  - W_COMMIT: entered when both are latched. In this single cycle:
    - Index < NUM_REGS and RO_MASK[i]=0: update the bytes where WSTRB=1, pulse reg_wr_pulse[i], BRESP=00.
    - Index >= NUM_REGS or RO_MASK[i]=1: no update, no pulse, BRESP=10.
  - W_RESP: BVALID=1 and held stable until BREADY; then return to W_COLLECT on the next cycle.
- Write latency: the register update and BVALID appear on the edge after the later of the AW/W handshakes plus one (the commit edge). reg_out reflects the new value in the same cycle BVALID rises.
- WSTRB=0 on a valid RW register: BRESP=00, no data change, reg_wr_pulse still asserted.
- Read FSM states:
  - R_IDLE: ARREADY=1. On handshake, RDATA/RRESP are registered at that same edge.
  - R_RESP: RVALID=1 with RDATA/RRESP held stable until RREADY; return to R_IDLE on the following edge.
  - Only one outstanding read.
- Read data: RW slot returns the register value; RO slot returns status_in sampled at the AR handshake edge. Index >= NUM_REGS returns RDATA=0, RRESP=10.
- Simultaneous read and write commit to the same register on the same edge: the read returns the old value.
- The read and write paths are fully independent; there is no arbitration stall.
- ARESET asserted while BVALID or RVALID is high: the valid drops at that edge and no response is reissued.

Test Plan:
- DATA_WIDTH=32, NUM_REGS=8, RO_MASK=0: write 0x1,0x2,0x3,0x4 to addresses 0x00,0x04,0x08,0x0C, then read them back -> RDATA 0x1..0x4, all RESP=00, reg_wr_pulse pulses on bits 0..3 one per write.
- Present W (0xAABBCCDD, WSTRB=4'b0101) three cycles before AW to 0x10 holding 0x11223344 -> reg 4 = 0x11BB33DD, BVALID exactly one cycle after the AW handshake.
- RO_MASK=8'h80, status_in slot 7 = 0xCAFEF00D: write 0x0 to 0x1C -> BRESP=10, no pulse; read 0x1C -> 0xCAFEF00D, RRESP=00.
- NUM_REGS=6: read 0x18 -> RDATA=0, RRESP=10; write 0x1C -> BRESP=10, no reg_out change.
- Hold BREADY/RREADY low for 5 cycles -> BVALID/RVALID and data stable, AWREADY/ARREADY low until the responses are accepted.
- DATA_WIDTH=64: write 0x0123456789ABCDEF to 0x08 -> reg 1 holds it. Assert ARESET mid-B-phase -> BVALID=0 at that edge, reg 1 = 0.

Source files
------------

// File: rtl/ecpri_axil_regbank_if.sv
// AXI4-Lite bus bundle for the eCPRI control-plane register bank.
// Signal names follow the AXI slave port naming used by the interconnect.
interface ecpri_axil_regbank_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR;
  logic                  S_AXI_AWVALID;
  logic                  S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0] S_AXI_WDATA;
  logic [STRB_W-1:0]     S_AXI_WSTRB;
  logic                  S_AXI_WVALID;
  logic                  S_AXI_WREADY;
  logic [1:0]            S_AXI_BRESP;
  logic                  S_AXI_BVALID;
  logic                  S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR;
  logic                  S_AXI_ARVALID;
  logic                  S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0] S_AXI_RDATA;
  logic [1:0]            S_AXI_RRESP;
  logic                  S_AXI_RVALID;
  logic                  S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/ecpri_axil_regbank.sv
// Parametrised AXI4-Lite register bank for the eCPRI control plane.
// RW slots drive reg_out, RO slots (RO_MASK) read back status_in, and every
// accepted RW write raises a one-cycle reg_wr_pulse for that slot.
module ecpri_axil_regbank #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 6,
  parameter int                  NUM_REGS   = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  ecpri_axil_regbank_if.slave            s_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] status_in
);
  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_COLLECT = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_t;

  // Byte-lane merge: lanes with a strobe take the new byte, others keep the old one.
  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_v,
    input logic [DATA_WIDTH-1:0] new_v,
    input logic [STRB_W-1:0]     strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int b = 0; b < STRB_W; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  w_state_t w_state_r, w_state_s;
  r_state_t r_state_r, r_state_s;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_r, regs_s;
  logic                  aw_ready_r, aw_ready_s, w_ready_r, w_ready_s;
  logic                  aw_have_r, aw_have_s, w_have_r, w_have_s;
  logic [IDX_W-1:0]      aw_idx_r, aw_idx_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [STRB_W-1:0]     wstrb_r, wstrb_s;
  logic                  b_valid_r, b_valid_s;
  logic [1:0]            b_resp_r, b_resp_s;
  logic [NUM_REGS-1:0]   wr_pulse_r, wr_pulse_s;
  logic                  ar_ready_r, ar_ready_s, r_valid_r, r_valid_s;
  logic [DATA_WIDTH-1:0] r_data_r, r_data_s, rd_data_s;
  logic [1:0]            r_resp_r, r_resp_s;
  logic                  rd_err_s, wr_hit_s, aw_hs_s, w_hs_s, ar_hs_s;
  logic [IDX_W-1:0]      ar_idx_s;
  logic                  unused_s;

  assign aw_hs_s  = s_axi.S_AXI_AWVALID && aw_ready_r;
  assign w_hs_s   = s_axi.S_AXI_WVALID && w_ready_r;
  assign ar_hs_s  = s_axi.S_AXI_ARVALID && ar_ready_r;
  assign ar_idx_s = s_axi.S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  // Sub-word address bits carry no information; RW-slot status bits are ignored.
  assign unused_s = ^{s_axi.S_AXI_AWADDR[ADDR_LSB-1:0], s_axi.S_AXI_ARADDR[ADDR_LSB-1:0], status_in};

  // Decode whether the latched write index names an existing writable slot.
  always_comb begin
    wr_hit_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit_s = wr_hit_s | ((aw_idx_r == IDX_W'(i)) && !RO_MASK[i]);
    end
  end

  // Read mux: RW slots return the register, RO slots the live status, misses flag SLVERR.
  always_comb begin
    rd_data_s = '0;
    rd_err_s  = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_err_s  = rd_err_s & (ar_idx_s != IDX_W'(i));
      rd_data_s = rd_data_s | ((ar_idx_s == IDX_W'(i))
                  ? (RO_MASK[i] ? status_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_r[i])
                  : {DATA_WIDTH{1'b0}});
    end
  end

  // Write FSM next state: collect AW and W independently, commit once, then hold B.
  always_comb begin
    w_state_s  = w_state_r;
    aw_ready_s = aw_ready_r;
    w_ready_s  = w_ready_r;
    aw_have_s  = aw_have_r;
    w_have_s   = w_have_r;
    aw_idx_s   = aw_idx_r;
    wdata_s    = wdata_r;
    wstrb_s    = wstrb_r;
    b_valid_s  = b_valid_r;
    b_resp_s   = b_resp_r;
    regs_s     = regs_r;
    wr_pulse_s = '0;
    case (w_state_r)
      W_COLLECT: begin
        if (aw_hs_s) begin
          aw_idx_s  = s_axi.S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
          aw_have_s = 1'b1;
        end else begin
          aw_have_s = aw_have_r;
        end
        if (w_hs_s) begin
          wdata_s  = s_axi.S_AXI_WDATA;
          wstrb_s  = s_axi.S_AXI_WSTRB;
          w_have_s = 1'b1;
        end else begin
          w_have_s = w_have_r;
        end
        if (aw_have_s && w_have_s) begin
          w_state_s  = W_COMMIT;
          aw_ready_s = 1'b0;
          w_ready_s  = 1'b0;
          aw_have_s  = 1'b0;
          w_have_s   = 1'b0;
        end else begin
          aw_ready_s = !aw_have_s;
          w_ready_s  = !w_have_s;
        end
      end
      W_COMMIT: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if ((aw_idx_r == IDX_W'(i)) && !RO_MASK[i]) begin
            regs_s[i]     = merge_bytes(regs_r[i], wdata_r, wstrb_r);
            wr_pulse_s[i] = 1'b1;
          end else begin
            regs_s[i]     = regs_r[i];
            wr_pulse_s[i] = 1'b0;
          end
        end
        b_resp_s  = wr_hit_s ? RESP_OKAY : RESP_SLVERR;
        b_valid_s = 1'b1;
        w_state_s = W_RESP;
      end
      W_RESP: begin
        if (s_axi.S_AXI_BREADY) begin
          b_valid_s  = 1'b0;
          aw_ready_s = 1'b1;
          w_ready_s  = 1'b1;
          w_state_s  = W_COLLECT;
        end else begin
          w_state_s  = W_RESP;
        end
      end
      default: begin
        w_state_s  = W_COLLECT;
        b_valid_s  = 1'b0;
        aw_ready_s = 1'b0;
        w_ready_s  = 1'b0;
        aw_have_s  = 1'b0;
        w_have_s   = 1'b0;
      end
    endcase
  end

  // Read FSM next state: one outstanding read, data captured at the AR handshake.
  always_comb begin
    r_state_s  = r_state_r;
    ar_ready_s = ar_ready_r;
    r_valid_s  = r_valid_r;
    r_data_s   = r_data_r;
    r_resp_s   = r_resp_r;
    case (r_state_r)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_data_s   = rd_data_s;
          r_resp_s   = rd_err_s ? RESP_SLVERR : RESP_OKAY;
          r_valid_s  = 1'b1;
          ar_ready_s = 1'b0;
          r_state_s  = R_RESP;
        end else begin
          ar_ready_s = 1'b1;
          r_state_s  = R_IDLE;
        end
      end
      R_RESP: begin
        if (s_axi.S_AXI_RREADY) begin
          r_valid_s  = 1'b0;
          ar_ready_s = 1'b1;
          r_state_s  = R_IDLE;
        end else begin
          r_state_s  = R_RESP;
        end
      end
      default: begin
        r_state_s  = R_IDLE;
        r_valid_s  = 1'b0;
        ar_ready_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_r  <= W_COLLECT;
      r_state_r  <= R_IDLE;
      regs_r     <= '0;
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      aw_have_r  <= 1'b0;
      w_have_r   <= 1'b0;
      aw_idx_r   <= '0;
      wdata_r    <= '0;
      wstrb_r    <= '0;
      b_valid_r  <= 1'b0;
      b_resp_r   <= 2'b00;
      wr_pulse_r <= '0;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      r_data_r   <= '0;
      r_resp_r   <= 2'b00;
    end else begin
      w_state_r  <= w_state_s;
      r_state_r  <= r_state_s;
      regs_r     <= regs_s;
      aw_ready_r <= aw_ready_s;
      w_ready_r  <= w_ready_s;
      aw_have_r  <= aw_have_s;
      w_have_r   <= w_have_s;
      aw_idx_r   <= aw_idx_s;
      wdata_r    <= wdata_s;
      wstrb_r    <= wstrb_s;
      b_valid_r  <= b_valid_s;
      b_resp_r   <= b_resp_s;
      wr_pulse_r <= wr_pulse_s;
      ar_ready_r <= ar_ready_s;
      r_valid_r  <= r_valid_s;
      r_data_r   <= r_data_s;
      r_resp_r   <= r_resp_s;
    end
  end

  assign s_axi.S_AXI_AWREADY = aw_ready_r;
  assign s_axi.S_AXI_WREADY  = w_ready_r;
  assign s_axi.S_AXI_BVALID  = b_valid_r;
  assign s_axi.S_AXI_BRESP   = b_resp_r;
  assign s_axi.S_AXI_ARREADY = ar_ready_r;
  assign s_axi.S_AXI_RVALID  = r_valid_r;
  assign s_axi.S_AXI_RDATA   = r_data_r;
  assign s_axi.S_AXI_RRESP   = r_resp_r;
  assign reg_out             = regs_r;
  assign reg_wr_pulse        = wr_pulse_r;
endmodule

// File: tb/tb_ecpri_axil_regbank.sv
// Bench for ecpri_axil_regbank: three configurations (8 regs with RO slot 7,
// 6 regs, 64-bit data). A and B share one stimulus bus; C is driven by hand.
module tb_ecpri_axil_regbank;
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic arst, arst_c;
  int checks = 0;
  int failures = 0;

  ecpri_axil_regbank_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) ifa ();
  ecpri_axil_regbank_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) ifb ();
  ecpri_axil_regbank_if #(.ADDR_WIDTH(6), .DATA_WIDTH(64)) ifc ();

  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  assign ifa.S_AXI_AWADDR = awaddr;  assign ifb.S_AXI_AWADDR = awaddr;
  assign ifa.S_AXI_AWVALID = awvalid; assign ifb.S_AXI_AWVALID = awvalid;
  assign ifa.S_AXI_WDATA = wdata;    assign ifb.S_AXI_WDATA = wdata;
  assign ifa.S_AXI_WSTRB = wstrb;    assign ifb.S_AXI_WSTRB = wstrb;
  assign ifa.S_AXI_WVALID = wvalid;  assign ifb.S_AXI_WVALID = wvalid;
  assign ifa.S_AXI_BREADY = bready;  assign ifb.S_AXI_BREADY = bready;
  assign ifa.S_AXI_ARADDR = araddr;  assign ifb.S_AXI_ARADDR = araddr;
  assign ifa.S_AXI_ARVALID = arvalid; assign ifb.S_AXI_ARVALID = arvalid;
  assign ifa.S_AXI_RREADY = rready;  assign ifb.S_AXI_RREADY = rready;

  logic [255:0] reg_out_a, status_a;
  logic [7:0]   pulse_a;
  logic [191:0] reg_out_b, status_b;
  logic [5:0]   pulse_b;
  logic [511:0] reg_out_c, status_c;
  logic [7:0]   pulse_c;

  ecpri_axil_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(8), .RO_MASK(8'h80)) dut_a (
    .ACLK(aclk), .ARESET(arst), .s_axi(ifa), .reg_out(reg_out_a),
    .reg_wr_pulse(pulse_a), .status_in(status_a));
  ecpri_axil_regbank #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(6), .RO_MASK(6'h00)) dut_b (
    .ACLK(aclk), .ARESET(arst), .s_axi(ifb), .reg_out(reg_out_b),
    .reg_wr_pulse(pulse_b), .status_in(status_b));
  ecpri_axil_regbank #(.DATA_WIDTH(64), .ADDR_WIDTH(6), .NUM_REGS(8), .RO_MASK(8'h00)) dut_c (
    .ACLK(aclk), .ARESET(arst_c), .s_axi(ifc), .reg_out(reg_out_c),
    .reg_wr_pulse(pulse_c), .status_in(status_c));

  typedef struct {
    logic        is_rd;
    logic [5:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_da;
    logic [1:0]  exp_ra;
    logic [7:0]  exp_pa;
    logic [31:0] exp_db;
    logic [1:0]  exp_rb;
    logic [5:0]  exp_pb;
  } vec_t;
  vec_t vecs[17];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] ra, output logic [1:0] rb,
                          output logic [7:0] pa, output logic [5:0] pb);
    logic aw_done, w_done, hs_aw, hs_w;
    int cyc;
    pa = '0; pb = '0; ra = 2'b11; rb = 2'b11;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      hs_aw = awvalid && ifa.S_AXI_AWREADY;
      hs_w  = wvalid && ifa.S_AXI_WREADY;
      @(posedge aclk); #1; cyc++;
      if (hs_aw) begin awvalid = 1'b0; aw_done = 1'b1; end
      if (hs_w) begin wvalid = 1'b0; w_done = 1'b1; end
      pa |= pulse_a; pb |= pulse_b;
    end
    check("wr_handshake_timeout", {aw_done, w_done}, 2'b11);
    awvalid = 1'b0; wvalid = 1'b0;
    cyc = 0;
    while (!ifa.S_AXI_BVALID && cyc < 20) begin
      @(posedge aclk); #1; cyc++;
      pa |= pulse_a; pb |= pulse_b;
    end
    check("wr_bvalid_timeout", ifa.S_AXI_BVALID, 1'b1);
    ra = ifa.S_AXI_BRESP; rb = ifb.S_AXI_BRESP;
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    pa |= pulse_a; pb |= pulse_b;
  endtask

  task automatic do_read(input logic [5:0] a,
                         output logic [31:0] da, output logic [1:0] ra,
                         output logic [31:0] db, output logic [1:0] rb);
    logic hs;
    int cyc;
    araddr = a; arvalid = 1'b1; cyc = 0;
    while (arvalid && cyc < 20) begin
      hs = ifa.S_AXI_ARREADY;
      @(posedge aclk); #1; cyc++;
      if (hs) arvalid = 1'b0;
    end
    check("rd_handshake_timeout", arvalid, 1'b0);
    arvalid = 1'b0;
    cyc = 0;
    while (!ifa.S_AXI_RVALID && cyc < 20) begin
      @(posedge aclk); #1; cyc++;
    end
    check("rd_rvalid_timeout", ifa.S_AXI_RVALID, 1'b1);
    da = ifa.S_AXI_RDATA; ra = ifa.S_AXI_RRESP;
    db = ifb.S_AXI_RDATA; rb = ifb.S_AXI_RRESP;
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  ra, rb;
    logic [31:0] da, db;
    logic [7:0]  pa;
    logic [5:0]  pb;
    logic        hs_aw, hs_w, hs_ar;
    int          cyc;

    //  rd    addr   data          strb   exp_da        ra     pa     exp_db  rb     pb
    vecs[0]  = '{1'b0, 6'h00, 32'h1,        4'hF, 32'h0,        2'b00, 8'h01, 32'h0,  2'b00, 6'h01};
    vecs[1]  = '{1'b0, 6'h04, 32'h2,        4'hF, 32'h0,        2'b00, 8'h02, 32'h0,  2'b00, 6'h02};
    vecs[2]  = '{1'b0, 6'h08, 32'h3,        4'hF, 32'h0,        2'b00, 8'h04, 32'h0,  2'b00, 6'h04};
    vecs[3]  = '{1'b0, 6'h0C, 32'h4,        4'hF, 32'h0,        2'b00, 8'h08, 32'h0,  2'b00, 6'h08};
    vecs[4]  = '{1'b1, 6'h00, 32'h0,        4'h0, 32'h1,        2'b00, 8'h00, 32'h1,  2'b00, 6'h00};
    vecs[5]  = '{1'b1, 6'h04, 32'h0,        4'h0, 32'h2,        2'b00, 8'h00, 32'h2,  2'b00, 6'h00};
    vecs[6]  = '{1'b1, 6'h08, 32'h0,        4'h0, 32'h3,        2'b00, 8'h00, 32'h3,  2'b00, 6'h00};
    vecs[7]  = '{1'b1, 6'h0C, 32'h0,        4'h0, 32'h4,        2'b00, 8'h00, 32'h4,  2'b00, 6'h00};
    vecs[8]  = '{1'b0, 6'h1C, 32'h0,        4'hF, 32'h0,        2'b10, 8'h00, 32'h0,  2'b10, 6'h00};
    vecs[9]  = '{1'b1, 6'h1C, 32'h0,        4'h0, 32'hCAFEF00D, 2'b00, 8'h00, 32'h0,  2'b10, 6'h00};
    vecs[10] = '{1'b0, 6'h18, 32'h66,       4'hF, 32'h0,        2'b00, 8'h40, 32'h0,  2'b10, 6'h00};
    vecs[11] = '{1'b1, 6'h18, 32'h0,        4'h0, 32'h66,       2'b00, 8'h00, 32'h0,  2'b10, 6'h00};
    vecs[12] = '{1'b0, 6'h14, 32'h12345678, 4'h0, 32'h0,        2'b00, 8'h20, 32'h0,  2'b00, 6'h20};
    vecs[13] = '{1'b1, 6'h14, 32'h0,        4'h0, 32'h0,        2'b00, 8'h00, 32'h0,  2'b00, 6'h00};
    vecs[14] = '{1'b0, 6'h01, 32'h99,       4'hF, 32'h0,        2'b00, 8'h01, 32'h0,  2'b00, 6'h01};
    vecs[15] = '{1'b1, 6'h03, 32'h0,        4'h0, 32'h99,       2'b00, 8'h00, 32'h99, 2'b00, 6'h00};
    vecs[16] = '{1'b0, 6'h10, 32'h11223344, 4'hF, 32'h0,        2'b00, 8'h10, 32'h0,  2'b00, 6'h10};

    status_a = '0;
    for (int i = 0; i < 8; i++) status_a[i*32 +: 32] = 32'h5A5A0000 + 32'(i);
    status_a[7*32 +: 32] = 32'hCAFEF00D;
    status_b = {192{1'b1}};
    status_c = '0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    ifc.S_AXI_AWADDR = '0; ifc.S_AXI_AWVALID = 1'b0; ifc.S_AXI_WDATA = '0;
    ifc.S_AXI_WSTRB = '0; ifc.S_AXI_WVALID = 1'b0; ifc.S_AXI_BREADY = 1'b0;
    ifc.S_AXI_ARADDR = '0; ifc.S_AXI_ARVALID = 1'b0; ifc.S_AXI_RREADY = 1'b0;
    arst = 1'b1; arst_c = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", ifa.S_AXI_AWREADY, 1'b0);
    check("rst_arready", ifa.S_AXI_ARREADY, 1'b0);
    check("rst_bvalid", ifa.S_AXI_BVALID, 1'b0);
    check("rst_rvalid", ifa.S_AXI_RVALID, 1'b0);
    check("rst_resp", {ifa.S_AXI_BRESP, ifa.S_AXI_RRESP}, 4'b0000);
    check("rst_rdata", ifa.S_AXI_RDATA, 32'h0);
    check("rst_reg_out", reg_out_a, 256'h0);
    check("rst_pulse", pulse_a, 8'h00);
    arst = 1'b0; arst_c = 1'b0;
    @(posedge aclk); #1;
    check("rst_ready_after", {ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, ifa.S_AXI_ARREADY}, 3'b111);

    // Table-driven single transactions on A and B
    for (int k = 0; k < 17; k++) begin
      if (vecs[k].is_rd) begin
        do_read(vecs[k].addr, da, ra, db, rb);
        check($sformatf("v%0d_rdata_a", k), da, vecs[k].exp_da);
        check($sformatf("v%0d_rresp_a", k), ra, vecs[k].exp_ra);
        check($sformatf("v%0d_rdata_b", k), db, vecs[k].exp_db);
        check($sformatf("v%0d_rresp_b", k), rb, vecs[k].exp_rb);
      end else begin
        do_write(vecs[k].addr, vecs[k].data, vecs[k].strb, ra, rb, pa, pb);
        check($sformatf("v%0d_bresp_a", k), ra, vecs[k].exp_ra);
        check($sformatf("v%0d_pulse_a", k), pa, vecs[k].exp_pa);
        check($sformatf("v%0d_bresp_b", k), rb, vecs[k].exp_rb);
        check($sformatf("v%0d_pulse_b", k), pb, vecs[k].exp_pb);
      end
    end
    check("table_reg_out_a", reg_out_a,
          {32'h0, 32'h66, 32'h0, 32'h11223344, 32'h4, 32'h3, 32'h2, 32'h99});
    check("table_reg_out_b", reg_out_b,
          {32'h0, 32'h11223344, 32'h4, 32'h3, 32'h2, 32'h99});

    // W three cycles ahead of AW, partial strobes, then B backpressure
    wdata = 32'hAABBCCDD; wstrb = 4'b0101; wvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      hs_w = wvalid && ifa.S_AXI_WREADY;
      @(posedge aclk); #1;
      if (hs_w) wvalid = 1'b0;
    end
    check("wfirst_w_taken", {wvalid, ifa.S_AXI_WREADY, ifa.S_AXI_AWREADY, ifa.S_AXI_BVALID}, 4'b0010);
    awaddr = 6'h10; awvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0;
    check("wfirst_bvalid_at_hs", ifa.S_AXI_BVALID, 1'b0);
    @(posedge aclk); #1;
    check("wfirst_bvalid_next", {ifa.S_AXI_BVALID, ifa.S_AXI_BRESP}, 3'b100);
    check("wfirst_reg4_a", reg_out_a[4*32 +: 32], 32'h11BB33DD);
    check("wfirst_reg4_b", reg_out_b[4*32 +: 32], 32'h11BB33DD);
    check("wfirst_pulse_a", pulse_a, 8'h10);
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      check("bstall_state", {ifa.S_AXI_BVALID, ifa.S_AXI_BRESP, ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY, pulse_a},
            {1'b1, 2'b00, 1'b0, 1'b0, 8'h00});
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    check("bstall_release", {ifa.S_AXI_BVALID, ifa.S_AXI_AWREADY, ifa.S_AXI_WREADY}, 3'b011);

    // R backpressure
    check("rstall_arready_pre", ifa.S_AXI_ARREADY, 1'b1);
    araddr = 6'h10; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("rstall_first", {ifa.S_AXI_RVALID, ifa.S_AXI_RRESP, ifa.S_AXI_RDATA}, {1'b1, 2'b00, 32'h11BB33DD});
    for (int c = 0; c < 5; c++) begin
      @(posedge aclk); #1;
      check("rstall_state", {ifa.S_AXI_RVALID, ifa.S_AXI_ARREADY, ifa.S_AXI_RDATA}, {1'b1, 1'b0, 32'h11BB33DD});
    end
    rready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0;
    check("rstall_release", {ifa.S_AXI_RVALID, ifa.S_AXI_ARREADY}, 2'b01);

    // Read handshake on the same edge as a write commit to the same register
    awaddr = 6'h08; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(posedge aclk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h08; arvalid = 1'b1;
    @(posedge aclk); #1;
    arvalid = 1'b0;
    check("collide_valids", {ifa.S_AXI_BVALID, ifa.S_AXI_RVALID}, 2'b11);
    check("collide_old_rdata", ifa.S_AXI_RDATA, 32'h3);
    check("collide_new_reg", reg_out_a[2*32 +: 32], 32'h77);
    bready = 1'b1; rready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0; rready = 1'b0;
    check("collide_done", {ifa.S_AXI_BVALID, ifa.S_AXI_RVALID}, 2'b00);

    // 64-bit instance: write, read back while B is pending, reset during B phase
    ifc.S_AXI_AWADDR = 6'h08; ifc.S_AXI_WDATA = 64'h0123456789ABCDEF;
    ifc.S_AXI_WSTRB = 8'hFF; ifc.S_AXI_AWVALID = 1'b1; ifc.S_AXI_WVALID = 1'b1;
    cyc = 0;
    while (!ifc.S_AXI_BVALID && cyc < 20) begin
      hs_aw = ifc.S_AXI_AWVALID && ifc.S_AXI_AWREADY;
      hs_w  = ifc.S_AXI_WVALID && ifc.S_AXI_WREADY;
      @(posedge aclk); #1; cyc++;
      if (hs_aw) ifc.S_AXI_AWVALID = 1'b0;
      if (hs_w) ifc.S_AXI_WVALID = 1'b0;
    end
    ifc.S_AXI_AWVALID = 1'b0; ifc.S_AXI_WVALID = 1'b0;
    check("c64_bvalid", {ifc.S_AXI_BVALID, ifc.S_AXI_BRESP}, 3'b100);
    check("c64_reg1", reg_out_c[64 +: 64], 64'h0123456789ABCDEF);
    check("c64_pulse", pulse_c, 8'h02);
    ifc.S_AXI_ARADDR = 6'h0A; ifc.S_AXI_ARVALID = 1'b1;
    cyc = 0;
    while (!ifc.S_AXI_RVALID && cyc < 20) begin
      hs_ar = ifc.S_AXI_ARVALID && ifc.S_AXI_ARREADY;
      @(posedge aclk); #1; cyc++;
      if (hs_ar) ifc.S_AXI_ARVALID = 1'b0;
    end
    ifc.S_AXI_ARVALID = 1'b0;
    check("c64_rdata", {ifc.S_AXI_RVALID, ifc.S_AXI_RRESP, ifc.S_AXI_RDATA}, {1'b1, 2'b00, 64'h0123456789ABCDEF});
    ifc.S_AXI_RREADY = 1'b1;
    @(posedge aclk); #1;
    ifc.S_AXI_RREADY = 1'b0;
    check("c64_bvalid_held", ifc.S_AXI_BVALID, 1'b1);
    arst_c = 1'b1;
    @(posedge aclk); #1;
    check("c64_rst_bvalid", ifc.S_AXI_BVALID, 1'b0);
    check("c64_rst_reg1", reg_out_c[64 +: 64], 64'h0);
    check("c64_rst_awready", ifc.S_AXI_AWREADY, 1'b0);
    arst_c = 1'b0;
    @(posedge aclk); #1;
    check("c64_post_rst", {ifc.S_AXI_AWREADY, ifc.S_AXI_ARREADY, ifc.S_AXI_BVALID}, 3'b110);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
